// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and state encoding for the seven-segment scanner
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // All segments off (active low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex-to-segment table, active low, bit order {g,f,e,d,c,b,a}; entry n is HEX_SEG[n]
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - nibble to active-low segment decoder with blank override
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup, forced dark when the digit is suppressed
  always_comb begin
    seg = HEX_SEG[nibble];
    if (blank) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - four-digit multiplexed seven-segment scan controller
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV  = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  input  logic [3:0]  dp_in,
  output logic [6:0]  cathodes,
  output logic        dp,
  output logic [3:0]  AN,
  output logic        scan_tick
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("seg7_scan_ctrl: CLK_DIV must be at least 2");
  end

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 2);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [15:0]             shadow_q, shadow_d;
  logic [15:0]             frame_q, frame_d;
  logic [NUM_DIGITS-1:0]   dpf_q, dpf_d;
  logic [3:0]              an_q, an_d;
  logic [6:0]              cathodes_q, cathodes_d;
  logic                    dp_q, dp_d;
  logic                    scan_tick_q, scan_tick_d;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    lz_run;
  logic [3:0]              cur_nibble;
  logic                    cur_blank;
  logic [6:0]              cur_seg;

  // Slot sequencing: one blank cycle, then CLK_DIV-1 drive cycles, then advance digit
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      BLANK: begin
        state_d = DRIVE;
        cnt_d   = '0;
      end
      DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = BLANK;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Shadow captures every strobe; the frame swaps only when blanking ahead of digit 0
  always_comb begin
    shadow_d = data_valid ? data_in : shadow_q;
    frame_d  = frame_q;
    dpf_d    = dpf_q;
    if (state_q == BLANK && idx_q == '0) begin
      frame_d = data_valid ? data_in : shadow_q;
      dpf_d   = dp_in;
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (frame_q[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_run;
    end
  end

  assign cur_nibble = frame_q[{idx_q, 2'b00} +: 4];
  assign cur_blank  = BLANK_LZ && lz_mask[idx_q];

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .blank  (cur_blank),
    .seg    (cur_seg)
  );

  // Output stage: dark with a tick during blank, otherwise drive the current digit
  always_comb begin
    an_d        = 4'b1111;
    cathodes_d  = SEG_BLANK;
    dp_d        = 1'b1;
    scan_tick_d = 1'b0;
    if (state_q == BLANK) begin
      scan_tick_d = 1'b1;
    end else begin
      an_d       = ~(4'b0001 << idx_q);
      cathodes_d = cur_seg;
      dp_d       = ~dpf_q[idx_q];
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= BLANK;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      frame_q     <= '0;
      dpf_q       <= '0;
      an_q        <= 4'b1111;
      cathodes_q  <= SEG_BLANK;
      dp_q        <= 1'b1;
      scan_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      frame_q     <= frame_d;
      dpf_q       <= dpf_d;
      an_q        <= an_d;
      cathodes_q  <= cathodes_d;
      dp_q        <= dp_d;
      scan_tick_q <= scan_tick_d;
    end
  end

  assign AN        = an_q;
  assign cathodes  = cathodes_q;
  assign dp        = dp_q;
  assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;
  logic [3:0]  dp_in;

  logic [6:0]  cath_a, cath_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a, an_b;
  logic        tick_a, tick_b;

  int n_checks = 0;
  int n_pass   = 0;

  seg7_scan_ctrl #(.CLK_DIV(4), .BLANK_LZ(1'b1)) dut (
    .sysclk     (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .dp_in      (dp_in),
    .cathodes   (cath_a),
    .dp         (dp_a),
    .AN         (an_a),
    .scan_tick  (tick_a)
  );

  seg7_scan_ctrl #(.CLK_DIV(4), .BLANK_LZ(1'b0)) dut_nolz (
    .sysclk     (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .dp_in      (dp_in),
    .cathodes   (cath_b),
    .dp         (dp_b),
    .AN         (an_b),
    .scan_tick  (tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lit segments per hex digit, active high in {g,f,e,d,c,b,a}
  logic [6:0] lit_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: cycle number since reset release; slots are 4 cycles, frames 16
  bit          mlive = 0;
  bit          mact  = 0;
  int          mk    = 0;
  logic [15:0] m_shadow, m_frame;
  logic [3:0]  m_dpf;

  always @(posedge clk) begin
    if (reset) begin
      mlive    = 1;
      mact     = 0;
      mk       = 0;
      m_shadow = '0;
      m_frame  = '0;
      m_dpf    = '0;
    end else begin
      if (mact) mk = mk + 1;
      else mk = 0;
      mact = 1;
      if (mk % 16 == 0) begin
        m_frame = data_valid ? data_in : m_shadow;
        m_dpf   = dp_in;
      end
      if (data_valid) m_shadow = data_in;
    end
  end

  function automatic logic [12:0] model_out(input bit lz);
    int pos, d;
    logic [15:0] upper;
    logic [6:0] seg;
    if (!mact) return {4'hF, 7'h7F, 1'b1, 1'b0};
    pos = mk % 4;
    d   = (mk / 4) % 4;
    if (pos == 0) return {4'hF, 7'h7F, 1'b1, 1'b1};
    upper = m_frame >> (4 * d);
    seg = ~lit_tab[upper[3:0]];
    if (lz && d > 0 && upper == 16'h0) seg = 7'h7F;
    return {~(4'b0001 << d), seg, ~m_dpf[d], 1'b0};
  endfunction

  always @(negedge clk) begin
    if (mlive) begin
      logic [12:0] ea, eb;
      ea = model_out(1'b1);
      eb = model_out(1'b0);
      n_checks++;
      if ({an_a, cath_a, dp_a, tick_a} === ea) n_pass++;
      else $display("FAIL model_lz k=%0d: got %h expected %h", mk, {an_a, cath_a, dp_a, tick_a}, ea);
      n_checks++;
      if ({an_b, cath_b, dp_b, tick_b} === eb) n_pass++;
      else $display("FAIL model_nolz k=%0d: got %h expected %h", mk, {an_b, cath_b, dp_b, tick_b}, eb);
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    int guard;
    guard = 0;
    do begin
      step(1);
      guard++;
    end while (!(mact && mk == target) && guard < 300);
    if (!(mact && mk == target)) chk("step_to_timeout", 16'(guard), 16'(target));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"},   16'(an_a),   16'hF);
    chk({tag, "_cath"}, 16'(cath_a), 16'h7F);
    chk({tag, "_dp"},   16'(dp_a),   16'h1);
    chk({tag, "_tick"}, 16'(tick_a), 16'h0);
  endtask

  initial begin
    reset = 1'b1; data_valid = 1'b0; data_in = '0; dp_in = '0;
    step(3);
    chk_reset_vals("reset");

    // 1234 strobed in the cycle that loads the first frame
    reset = 1'b0; data_valid = 1'b1; data_in = 16'h1234;
    step_to(0);
    data_valid = 1'b0;
    chk("first_tick", 16'(tick_a), 16'h1);
    chk("first_an", 16'(an_a), 16'hF);
    step_to(1);  chk("d0_an", 16'(an_a), 16'hE); chk("d0_cath", 16'(cath_a), 16'b0011001);
    step_to(3);  chk("d0_hold", 16'(an_a), 16'hE);
    step_to(4);  chk("gap_an", 16'(an_a), 16'hF); chk("gap_tick", 16'(tick_a), 16'h1);
    step_to(5);  chk("d1_an", 16'(an_a), 16'hD); chk("d1_cath", 16'(cath_a), 16'b0110000);
    step_to(9);  chk("d2_an", 16'(an_a), 16'hB); chk("d2_cath", 16'(cath_a), 16'b0100100);
    step_to(13); chk("d3_an", 16'(an_a), 16'h7); chk("d3_cath", 16'(cath_a), 16'b1111001);

    // Mid-frame strobe must not tear the current frame
    step_to(21);
    data_valid = 1'b1; data_in = 16'hAAAA;
    step(1);
    data_valid = 1'b0;
    step_to(25); chk("tear_d2", 16'(cath_a), 16'b0100100);
    step_to(29); chk("tear_d3", 16'(cath_a), 16'b1111001);
    step_to(33); chk("aaaa_d0", 16'(cath_a), 16'b0001000);
    data_valid = 1'b1; data_in = 16'h0050;
    step(1);
    data_valid = 1'b0;
    step_to(45); chk("aaaa_d3", 16'(cath_a), 16'b0001000);

    // Leading-zero blanking of 0050
    step_to(49); chk("lz50_d0", 16'(cath_a), 16'b1000000);
    data_valid = 1'b1; data_in = 16'h0000;
    step(1);
    data_valid = 1'b0;
    step_to(53); chk("lz50_d1", 16'(cath_a), 16'b0010010);
    step_to(57);
    chk("lz50_d2_an", 16'(an_a), 16'hB); chk("lz50_d2", 16'(cath_a), 16'h7F);
    chk("nolz50_d2", 16'(cath_b), 16'b1000000);
    step_to(61);
    chk("lz50_d3_an", 16'(an_a), 16'h7); chk("lz50_d3", 16'(cath_a), 16'h7F);
    chk("nolz50_d3", 16'(cath_b), 16'b1000000);

    // All-zero value leaves only digit 0 lit
    step_to(65); chk("lz0_d0", 16'(cath_a), 16'b1000000);
    step_to(69); chk("lz0_d1_an", 16'(an_a), 16'hD); chk("lz0_d1", 16'(cath_a), 16'h7F);
    step_to(77); chk("lz0_d3", 16'(cath_a), 16'h7F);

    // Strobe and dp request in the frame-load cycle itself
    step_to(79);
    data_valid = 1'b1; data_in = 16'hF00D; dp_in = 4'b0101;
    step(1);
    data_valid = 1'b0; dp_in = 4'b0000;
    chk("f00d_tick", 16'(tick_a), 16'h1);
    step_to(81); chk("f00d_d0", 16'(cath_a), 16'b0100001); chk("f00d_dp0", 16'(dp_a), 16'h0);
    step_to(85); chk("f00d_d1", 16'(cath_a), 16'b1000000); chk("f00d_dp1", 16'(dp_a), 16'h1);
    step_to(89); chk("f00d_d2", 16'(cath_a), 16'b1000000); chk("f00d_dp2", 16'(dp_a), 16'h0);
    step_to(93); chk("f00d_d3", 16'(cath_a), 16'b0001110); chk("f00d_dp3", 16'(dp_a), 16'h1);

    // Reset in the middle of digit 2's slot
    step_to(105);
    chk("pre_rst_an", 16'(an_a), 16'hB);
    reset = 1'b1;
    step(1);
    chk_reset_vals("midrst");
    reset = 1'b0;
    step(1);
    chk("rst_tick", 16'(tick_a), 16'h1); chk("rst_blank_an", 16'(an_a), 16'hF);
    step(1);
    chk("rst_d0_an", 16'(an_a), 16'hE); chk("rst_d0", 16'(cath_a), 16'b1000000);
    step(4);
    chk("rst_d1_an", 16'(an_a), 16'hD); chk("rst_d1", 16'(cath_a), 16'h7F);
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
